mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/mem_timeout_cnt.sv | 37 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_t      : arbiter FSM state encoding
//   DEFAULT_TIMEOUT  : default number of unacknowledged request cycles before abort
//   TIMEOUT_CNT_W    : width of the timeout counter (covers TIMEOUT up to 255)
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 15;
  localparam int TIMEOUT_CNT_W   = 8;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts cycles a memory access has been waiting for an acknowledge.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset (count -> 0)
//   clear   : force count to 0 (held while no access is in flight)
//   enable  : advance count by one this cycle
//   expired : count has reached TIMEOUT-1, i.e. this is the last allowed wait cycle
module mem_timeout_cnt
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_CNT_W-1:0] LIMIT = TIMEOUT_CNT_W'(TIMEOUT - 1);

  logic [TIMEOUT_CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // The arbiter stops enabling once expired, so the count never wraps.
  assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single shared memory bus between the instruction fetch port
// and the data port. Data requests win ties. Each access is latched, held
// stable on the bus until mem_ack or timeout, then completed with a one-cycle
// ready pulse (plus bus_err on timeout) before the next grant.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   if_req/if_addr/if_rdata/if_ready   : fetch port
//   dm_req/dm_we/dm_addr/dm_wdata      : data port request
//   dm_rdata/dm_ready                  : data port response
//   mem_req/mem_we/mem_addr/mem_wdata  : shared memory request
//   mem_rdata/mem_ack                  : shared memory response
//   stall                              : pipeline hold while any port waits
//   bus_err                            : one-cycle pulse on timeout abort
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          stall,
  output logic          bus_err
);

  arb_state_t    state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic          we_reg, we_next;
  logic          grant_dm_reg, grant_dm_next;
  logic          aborted_reg, aborted_next;
  logic [31:0]   if_rdata_reg, if_rdata_next;
  logic [31:0]   dm_rdata_reg, dm_rdata_next;

  logic in_acc;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  assign in_acc = (state_reg == IF_ACC) || (state_reg == DM_ACC);

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      grant_dm_reg <= 1'b0;
      aborted_reg  <= 1'b0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      we_reg       <= we_next;
      grant_dm_reg <= grant_dm_next;
      aborted_reg  <= aborted_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    we_next       = we_reg;
    grant_dm_next = grant_dm_reg;
    aborted_next  = aborted_reg;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;
    // Counter sits at zero whenever no access is in flight, so it always
    // starts from zero on the first access cycle.
    cnt_clear     = ~in_acc;
    cnt_enable    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (dm_req) begin
          addr_next     = dm_addr;
          wdata_next    = dm_wdata;
          we_next       = dm_we;
          grant_dm_next = 1'b1;
          aborted_next  = 1'b0;
          state_next    = DM_ACC;
        end else if (if_req) begin
          addr_next     = if_addr;
          we_next       = 1'b0;
          grant_dm_next = 1'b0;
          aborted_next  = 1'b0;
          state_next    = IF_ACC;
        end
      end
      IF_ACC, DM_ACC: begin
        // An ack on the final allowed cycle still completes normally.
        if (mem_ack) begin
          if (grant_dm_reg) dm_rdata_next = mem_rdata;
          else              if_rdata_next = mem_rdata;
          state_next = DONE;
        end else if (cnt_expired) begin
          if (grant_dm_reg) dm_rdata_next = '0;
          else              if_rdata_next = '0;
          aborted_next = 1'b1;
          state_next   = DONE;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_req   = in_acc;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  assign if_ready  = (state_reg == DONE) && !grant_dm_reg;
  assign dm_ready  = (state_reg == DONE) &&  grant_dm_reg;
  assign bus_err   = (state_reg == DONE) &&  aborted_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;

  assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic          stall;
  logic          bus_err;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .TIMEOUT (4),
    .AW      (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start of a new cycle: inputs are driven just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge.
  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    // ---------------- reset ----------------
    next_cycle(); next_cycle();
    sample();
    chk("rst_mem_req",  32'(mem_req),  32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_dm_ready", 32'(dm_ready), 32'd0);
    chk("rst_bus_err",  32'(bus_err),  32'd0);
    chk("rst_if_rdata", if_rdata,      32'h0);
    chk("rst_dm_rdata", dm_rdata,      32'h0);
    chk("rst_mem_addr", mem_addr,      32'h0);
    chk("rst_stall",    32'(stall),    32'd0);
    next_cycle();
    rst_n = 1'b1;
    $display("reset: done");

    // ---------------- single fetch ----------------
    next_cycle();                         // cycle 0
    if_req = 1'b1; if_addr = 32'h400;
    sample();
    chk("f_c0_stall",   32'(stall),   32'd1);
    chk("f_c0_mem_req", 32'(mem_req), 32'd0);
    next_cycle();                         // cycle 1
    mem_ack = 1'b1; mem_rdata = 32'h2008000A;
    sample();
    chk("f_c1_mem_req",  32'(mem_req), 32'd1);
    chk("f_c1_mem_addr", mem_addr,     32'h400);
    chk("f_c1_mem_we",   32'(mem_we),  32'd0);
    chk("f_c1_stall",    32'(stall),   32'd1);
    next_cycle();                         // cycle 2
    mem_ack = 1'b0;
    sample();
    chk("f_c2_if_ready", 32'(if_ready), 32'd1);
    chk("f_c2_if_rdata", if_rdata,      32'h2008000A);
    chk("f_c2_stall",    32'(stall),    32'd0);
    chk("f_c2_mem_req",  32'(mem_req),  32'd0);
    chk("f_c2_bus_err",  32'(bus_err),  32'd0);
    next_cycle();                         // cycle 3
    if_req = 1'b0;
    sample();
    chk("f_c3_if_ready", 32'(if_ready), 32'd0);
    chk("f_c3_if_rdata_hold", if_rdata, 32'h2008000A);
    $display("fetch: addr=%h rdata=%h", 32'h400, if_rdata);

    // ---------------- contention ----------------
    next_cycle();                         // cycle 0
    if_req = 1'b1; if_addr = 32'h404;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000; dm_wdata = 32'h0;
    sample();
    chk("c_c0_stall", 32'(stall), 32'd1);
    next_cycle();                         // cycle 1: data port granted
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    sample();
    chk("c_c1_mem_req",  32'(mem_req), 32'd1);
    chk("c_c1_mem_addr", mem_addr,     32'h1000);
    chk("c_c1_mem_we",   32'(mem_we),  32'd0);
    next_cycle();                         // cycle 2: DONE
    mem_ack = 1'b0;
    sample();
    chk("c_c2_dm_ready", 32'(dm_ready), 32'd1);
    chk("c_c2_if_ready", 32'(if_ready), 32'd0);
    chk("c_c2_mem_req",  32'(mem_req),  32'd0);
    chk("c_c2_dm_rdata", dm_rdata,      32'h11112222);
    chk("c_c2_stall",    32'(stall),    32'd1);
    next_cycle();                         // cycle 3: IDLE, fetch pending
    dm_req = 1'b0;
    sample();
    chk("c_c3_mem_req", 32'(mem_req), 32'd0);
    next_cycle();                         // cycle 4: fetch granted
    mem_ack = 1'b1; mem_rdata = 32'h33334444;
    sample();
    chk("c_c4_mem_req",  32'(mem_req), 32'd1);
    chk("c_c4_mem_addr", mem_addr,     32'h404);
    next_cycle();                         // cycle 5
    mem_ack = 1'b0;
    sample();
    chk("c_c5_if_ready", 32'(if_ready), 32'd1);
    chk("c_c5_if_rdata", if_rdata,      32'h33334444);
    chk("c_c5_dm_rdata_hold", dm_rdata, 32'h11112222);
    next_cycle();
    if_req = 1'b0;
    $display("contention: dm_rdata=%h if_rdata=%h", dm_rdata, if_rdata);

    // ---------------- store with 3 wait states ----------------
    next_cycle();                         // cycle 0
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
    for (int i = 1; i <= 4; i++) begin    // cycles 1..4 in DM_ACC
      next_cycle();
      dm_wdata = 32'h0BAD0BAD;            // bus must keep the latched value
      if (i == 4) begin
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
      end
      sample();
      chk($sformatf("s_c%0d_mem_req", i),   32'(mem_req), 32'd1);
      chk($sformatf("s_c%0d_mem_we", i),    32'(mem_we),  32'd1);
      chk($sformatf("s_c%0d_mem_addr", i),  mem_addr,     32'h20);
      chk($sformatf("s_c%0d_mem_wdata", i), mem_wdata,    32'hDEADBEEF);
      chk($sformatf("s_c%0d_dm_ready", i),  32'(dm_ready), 32'd0);
    end
    next_cycle();                         // cycle 5
    mem_ack = 1'b0;
    sample();
    chk("s_c5_dm_ready", 32'(dm_ready), 32'd1);
    chk("s_c5_bus_err",  32'(bus_err),  32'd0);
    chk("s_c5_mem_req",  32'(mem_req),  32'd0);
    chk("s_c5_dm_rdata", dm_rdata,      32'h55AA55AA);
    next_cycle();
    dm_req = 1'b0; dm_we = 1'b0;
    $display("store: addr=%h wdata=%h", 32'h20, 32'hDEADBEEF);

    // ---------------- timeout ----------------
    next_cycle();                         // cycle 0
    if_req = 1'b1; if_addr = 32'h800;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      sample();
      chk($sformatf("t_c%0d_mem_req", i), 32'(mem_req), 32'd1);
      chk($sformatf("t_c%0d_bus_err", i), 32'(bus_err), 32'd0);
    end
    next_cycle();                         // cycle 5
    sample();
    chk("t_c5_mem_req",  32'(mem_req),  32'd0);
    chk("t_c5_if_ready", 32'(if_ready), 32'd1);
    chk("t_c5_bus_err",  32'(bus_err),  32'd1);
    chk("t_c5_if_rdata", if_rdata,      32'h0);
    next_cycle();                         // cycle 6
    if_req = 1'b0;
    sample();
    chk("t_c6_bus_err",  32'(bus_err),  32'd0);
    $display("timeout: if_rdata=%h", if_rdata);

    // ---------------- reset mid-access ----------------
    next_cycle();                         // cycle 0
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    next_cycle();                         // cycle 1
    sample();
    chk("r_c1_mem_req", 32'(mem_req), 32'd1);
    next_cycle();                         // cycle 2: reset asserted
    rst_n = 1'b0;
    next_cycle();                         // cycle 3: late ack, reset released
    rst_n = 1'b1; dm_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    sample();
    chk("r_c3_mem_req",  32'(mem_req),  32'd0);
    chk("r_c3_dm_ready", 32'(dm_ready), 32'd0);
    chk("r_c3_dm_rdata", dm_rdata,      32'h0);
    next_cycle();                         // cycle 4
    mem_ack = 1'b0;
    sample();
    chk("r_c4_dm_ready", 32'(dm_ready), 32'd0);
    chk("r_c4_bus_err",  32'(bus_err),  32'd0);
    chk("r_c4_dm_rdata", dm_rdata,      32'h0);
    next_cycle();                         // new request, cycle 0
    dm_req = 1'b1; dm_addr = 32'h44;
    next_cycle();                         // cycle 1
    mem_ack = 1'b1; mem_rdata = 32'h00000077;
    sample();
    chk("r_n1_mem_addr", mem_addr, 32'h44);
    next_cycle();                         // cycle 2
    mem_ack = 1'b0;
    sample();
    chk("r_n2_dm_ready", 32'(dm_ready), 32'd1);
    chk("r_n2_dm_rdata", dm_rdata,      32'h00000077);
    next_cycle();
    dm_req = 1'b0;
    $display("reset mid-access: recovered dm_rdata=%h", dm_rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
